// File: rtl/univ_derotate_reg_if.sv
// Command/status bundle for the derotate register: command side drives
// ctrl/data/restore_req, the register answers with its word and unwind status.
interface univ_derotate_reg_if #(
  parameter int DW = 4,
  parameter int OW = $clog2(DW)
);
  logic [1:0]    ctrl;
  logic [DW-1:0] data;
  logic          restore_req;
  logic [DW-1:0] q;
  logic [OW-1:0] offset;
  logic          busy;
  logic          done;
  logic          aligned;

  modport master (
    output ctrl, data, restore_req,
    input  q, offset, busy, done, aligned
  );

  modport slave (
    input  ctrl, data, restore_req,
    output q, offset, busy, done, aligned
  );
endinterface

// File: rtl/univ_derotate_reg.sv
// Rotate register that tracks net rotation since load and, on request, walks
// the word back to its loaded alignment one position per cycle, shortest way.
module univ_derotate_reg #(
  parameter int DW = 4,
  parameter int OW = $clog2(DW)
) (
  input  logic              clk,
  input  logic              sync_rst_n,
  univ_derotate_reg_if.slave bus
);
  typedef enum logic [1:0] {IDLE, UNWIND, DONE} state_t;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_ROL  = 2'b10;
  localparam logic [1:0] CMD_ROR  = 2'b01;

  localparam logic [OW-1:0] OMAX = OW'(DW - 1);
  localparam logic [OW-1:0] HALF = OW'(DW / 2);

  state_t        state;
  logic [DW-1:0] q_r;
  logic [OW-1:0] off_r;
  logic          dir_r;   // 1: unwind by rotating left
  logic          busy_r;
  logic          done_r;

  logic [DW-1:0] q_rol, q_ror;
  logic [OW-1:0] off_inc, off_dec, off_unw;

  assign q_rol   = {q_r[DW-2:0], q_r[DW-1]};
  assign q_ror   = {q_r[0], q_r[DW-1:1]};
  // Explicit modulo-DW wrap; DW need not be a power of two.
  assign off_inc = (off_r == OMAX) ? '0 : off_r + 1'b1;
  assign off_dec = (off_r == '0) ? OMAX : off_r - 1'b1;
  assign off_unw = dir_r ? off_inc : off_dec;

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state  <= IDLE;
      q_r    <= '0;
      off_r  <= '0;
      dir_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.restore_req) begin
            if (off_r != '0) begin
              state  <= UNWIND;
              busy_r <= 1'b1;
              dir_r  <= (off_r > HALF);  // tie goes right
            end else begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end else begin
            case (bus.ctrl)
              CMD_LOAD: begin q_r <= bus.data; off_r <= '0;      end
              CMD_ROL:  begin q_r <= q_rol;    off_r <= off_inc; end
              CMD_ROR:  begin q_r <= q_ror;    off_r <= off_dec; end
              default:  ;
            endcase
          end
        end
        UNWIND: begin
          q_r   <= dir_r ? q_rol : q_ror;
          off_r <= off_unw;
          if (off_unw == '0) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q       = q_r;
  assign bus.offset  = off_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.aligned = (off_r == '0);
endmodule
